terminal_request_encoder: RTL and testbench

TERMINAL_REQUEST_ENCODER -- requirements
Module: terminal_request_encoder

---
 rtl/terminal_request_encoder.sv | 188 ++++++++++++++++++
 tb/tb_terminal_request_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/terminal_request_encoder.sv
// terminal_request_encoder
// Turns a debounced SEND pushbutton press into a timed request on one of two
// terminal ports. Each press samples the switches once (LOAD), presents the
// request for HOLD_CYCLES cycles (HOLD) and then waits for the button to be
// released (WAIT_REL) before another press is accepted.
//
// Optional build macro: AUTO_CLEAR_EN. When defined, the request word HHx of
// the expiring terminal is cleared when its hold expires. When undefined, HHx
// keeps the last loaded word until that terminal is loaded again or reset.
//
// Handshake: VALIDx high means HHx/Bx carry a live request. There is no
// ready; the request is presented for exactly HOLD_CYCLES cycles and is not
// extended or queued. The FSM state is visible on state_dbg.
module terminal_request_encoder #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [2:0] SW_PROF,
  input  logic       SW_FUNC,
  input  logic [1:0] SW_OPT,
  input  logic       SW_TERM,
  input  logic       SEND_N,
  output logic [3:0] HH0,
  output logic [3:0] HH1,
  output logic [1:0] B0,
  output logic [1:0] B1,
  output logic       VALID0,
  output logic       VALID1,
  output logic       BUSY,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    HOLD     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic        sync1;
  logic        sync2;
  logic [1:0]  flush_cnt;
  logic        stable;
  logic [15:0] deb_cnt;
  logic        armed;
  logic        press;
  logic [15:0] hold_cnt;
  logic        load_en;
  logic        expire;

  // Two-flop synchronizer for the asynchronous button; idles released (1).
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= SEND_N;
      sync2 <= sync1;
    end
  end

  // Counts the cycles until the synchronizer holds a real sample after reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      flush_cnt <= 2'd0;
    end else if (flush_cnt != 2'd2) begin
      flush_cnt <= flush_cnt + 2'd1;
    end
  end

  // Debounce: the stable level follows sync2 only after DEB_CYCLES consecutive
  // differing samples. A press is flagged on an accepted 1->0 change, but only
  // once a genuine released level has been seen since reset, so a button held
  // through reset does not fire until it is released and pressed again.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stable  <= 1'b1;
      deb_cnt <= 16'd0;
      armed   <= 1'b0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == stable) begin
        deb_cnt <= 16'd0;
      end else if (deb_cnt >= DEB_LAST) begin
        stable  <= sync2;
        deb_cnt <= 16'd0;
        press   <= stable & armed;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
      if ((flush_cnt == 2'd2) && stable && sync2) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; presses outside IDLE are simply not looked at.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (press) state_d = LOAD;
      end
      LOAD: begin
        load_en = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (hold_cnt >= HOLD_LAST) begin
          expire  = 1'b1;
          state_d = WAIT_REL;
        end
      end
      WAIT_REL: begin
        if (stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold timer: cleared on entry to HOLD, counts up and saturates at the limit.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hold_cnt <= 16'd0;
    end else if (load_en) begin
      hold_cnt <= 16'd0;
    end else if ((state_q == HOLD) && (hold_cnt < HOLD_LAST)) begin
      hold_cnt <= hold_cnt + 16'd1;
    end
  end

  // Output registers: load the selected terminal, release on expiry.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      HH0    <= 4'b0000;
      HH1    <= 4'b0000;
      B0     <= 2'b11;
      B1     <= 2'b11;
      VALID0 <= 1'b0;
      VALID1 <= 1'b0;
    end else if (load_en) begin
      if (SW_TERM) begin
        HH1    <= {SW_PROF, SW_FUNC};
        B1     <= ~SW_OPT;
        VALID1 <= 1'b1;
      end else begin
        HH0    <= {SW_PROF, SW_FUNC};
        B0     <= ~SW_OPT;
        VALID0 <= 1'b1;
      end
    end else if (expire) begin
`ifdef AUTO_CLEAR_EN
      if (VALID0) HH0 <= 4'b0000;
      if (VALID1) HH1 <= 4'b0000;
`else
      HH0 <= HH0;
      HH1 <= HH1;
`endif
      VALID0 <= 1'b0;
      VALID1 <= 1'b0;
      B0     <= 2'b11;
      B1     <= 2'b11;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_terminal_request_encoder.sv
// Bench for terminal_request_encoder: directed vector table, hand-written
// multi-cycle sequences (glitch train, press during hold, reset mid-hold) and
// randomized requests checked against a transaction-level model.
module tb_terminal_request_encoder;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int RISE = DEB + 4;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] SW_PROF;
  logic       SW_FUNC;
  logic [1:0] SW_OPT;
  logic       SW_TERM;
  logic       SEND_N;
  logic [3:0] HH0;
  logic [3:0] HH1;
  logic [1:0] B0;
  logic [1:0] B1;
  logic       VALID0;
  logic       VALID1;
  logic       BUSY;
  logic [1:0] state_dbg;

  int tests = 0;
  int fails = 0;
  logic [6:0] exp_q[$];
  logic [3:0] model_hh[2];

  terminal_request_encoder #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .CLK(CLK), .RST_N(RST_N), .SW_PROF(SW_PROF), .SW_FUNC(SW_FUNC),
    .SW_OPT(SW_OPT), .SW_TERM(SW_TERM), .SEND_N(SEND_N),
    .HH0(HH0), .HH1(HH1), .B0(B0), .B1(B1),
    .VALID0(VALID0), .VALID1(VALID1), .BUSY(BUSY), .state_dbg(state_dbg)
  );

  // Clock.
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic        term;
    logic [2:0]  prof;
    logic        func;
    logic [1:0]  opt;
    int          low;
    int          pulses;
    logic [3:0]  exp_hh;
    logic [1:0]  exp_b;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] after_hold(input logic [3:0] w);
`ifdef AUTO_CLEAR_EN
    return 4'b0000 & w;
`else
    return w;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " HH0"}, 32'(HH0), 32'(model_hh[0]));
    check({tag, " HH1"}, 32'(HH1), 32'(model_hh[1]));
    check({tag, " B0"}, 32'(B0), 32'd3);
    check({tag, " B1"}, 32'(B1), 32'd3);
    check({tag, " VALID"}, 32'({VALID0, VALID1}), 32'd0);
    check({tag, " BUSY"}, 32'(BUSY), 32'd0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    SEND_N = 1'b1;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    model_hh[0] = 4'b0000;
    model_hh[1] = 4'b0000;
    exp_q.delete();
  endtask

  // One request window: SEND_N is low at cycle c when low_mask[c] is set.
  task automatic run_txn(input string tag, input logic term, input logic [2:0] prof,
                         input logic func, input logic [1:0] opt, input logic [63:0] low_mask,
                         input int ncyc, input int pulses, input logic [3:0] exp_hh,
                         input logic [1:0] exp_b);
    int rises = 0;
    int width = 0;
    int rise_at = -1;
    int busy_cnt = 0;
    int overlap = 0;
    int other = 0;
    int b_bad = 0;
    int waited = 0;
    logic prev_v = 1'b0;
    logic v;
    logic vo;
    logic [6:0] got;
    logic [6:0] want;
    SW_TERM = term; SW_PROF = prof; SW_FUNC = func; SW_OPT = opt;
    if (pulses > 0) exp_q.push_back({term, exp_hh, exp_b});
    for (int c = 0; c < ncyc; c++) begin
      SEND_N = ~low_mask[c];
      @(negedge CLK);
      v  = term ? VALID1 : VALID0;
      vo = term ? VALID0 : VALID1;
      if (VALID0 && VALID1) overlap++;
      if (vo) other++;
      if (BUSY) busy_cnt++;
      if (v && !prev_v) begin
        rises++;
        if (rise_at < 0) rise_at = c + 1;
        got = {term, (term ? HH1 : HH0), (term ? B1 : B0)};
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          check({tag, " request word"}, 32'(got), 32'(want));
        end else begin
          check({tag, " unexpected request"}, 32'(got), 32'd0 - 32'd1);
        end
        check({tag, " other HH during hold"}, 32'(term ? HH0 : HH1), 32'(model_hh[~term]));
      end
      if (v) begin
        width++;
        if ((term ? B1 : B0) !== exp_b) b_bad++;
      end
      if (!v && prev_v) begin
        check({tag, " HH at fall"}, 32'(term ? HH1 : HH0), 32'(after_hold(exp_hh)));
        check({tag, " B at fall"}, 32'(term ? B1 : B0), 32'd3);
      end
      if (c + 1 > RISE) begin
        SW_TERM = 1'($urandom); SW_PROF = 3'($urandom); SW_FUNC = 1'($urandom); SW_OPT = 2'($urandom);
      end
      prev_v = v;
    end
    SEND_N = 1'b1;
    while (BUSY && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    check({tag, " busy timeout"}, 32'(waited < 100), 32'd1);
    repeat (DEB + 4) @(negedge CLK);
    check({tag, " pulse count"}, 32'(rises), 32'(pulses));
    if (pulses > 0) begin
      check({tag, " latency"}, 32'(rise_at), 32'(RISE));
      check({tag, " width"}, 32'(width), 32'(HOLD));
      model_hh[term] = after_hold(exp_hh);
    end else begin
      check({tag, " busy cycles"}, 32'(busy_cnt), 32'd0);
    end
    check({tag, " overlap"}, 32'(overlap), 32'd0);
    check({tag, " other valid"}, 32'(other), 32'd0);
    check({tag, " B during hold"}, 32'(b_bad), 32'd0);
    check_idle_outputs(tag);
  endtask

  initial begin
    vec_t vecs[6];
    logic [63:0] mask;
    int l;
    logic t;
    logic [2:0] p;
    logic f;
    logic [1:0] o;
    int saw;

    RST_N = 1'b0; SEND_N = 1'b1;
    SW_PROF = 3'd0; SW_FUNC = 1'b0; SW_OPT = 2'd0; SW_TERM = 1'b0;

    vecs[0] = '{"basic t0",   1'b0, 3'b101, 1'b1, 2'b10, 10, 1, 4'b1011, 2'b01};
    vecs[1] = '{"load t1",    1'b1, 3'b011, 1'b0, 2'b01, 10, 1, 4'b0110, 2'b10};
    vecs[2] = '{"load t0",    1'b0, 3'b110, 1'b1, 2'b00, 10, 1, 4'b1101, 2'b11};
    vecs[3] = '{"short glt",  1'b1, 3'b000, 1'b1, 2'b11,  3, 0, 4'b0001, 2'b00};
    vecs[4] = '{"min press",  1'b1, 3'b111, 1'b1, 2'b11,  4, 1, 4'b1111, 2'b00};
    vecs[5] = '{"t0 opt01",   1'b0, 3'b010, 1'b0, 2'b01,  6, 1, 4'b0100, 2'b10};

    // Reset state.
    do_reset();
    @(negedge CLK);
    check_idle_outputs("reset");

    // Vector table.
    foreach (vecs[i]) begin
      mask = (64'd1 << vecs[i].low) - 64'd1;
      run_txn(vecs[i].tag, vecs[i].term, vecs[i].prof, vecs[i].func, vecs[i].opt,
              mask, 40, vecs[i].pulses, vecs[i].exp_hh, vecs[i].exp_b);
    end

    // Five 3-cycle glitches separated by 2 released cycles: never a press.
    mask = 64'h0000_0000_0073_9CE7;
    run_txn("glitch train", 1'b0, 3'b111, 1'b1, 2'b11, mask, 40, 0, 4'b1111, 2'b00);

    // Second press during HOLD is ignored: one pulse of HOLD cycles only.
    mask = 64'h0000_0000_0003_FF0F;
    run_txn("press in hold", 1'b1, 3'b100, 1'b1, 2'b01, mask, 40, 1, 4'b1001, 2'b10);

    // Reset during HOLD cycle 4 with the button still held.
    SW_TERM = 1'b0; SW_PROF = 3'b101; SW_FUNC = 1'b1; SW_OPT = 2'b10;
    SEND_N = 1'b0;
    saw = 0;
    for (int s = 1; s <= 30; s++) begin
      @(negedge CLK);
      if (s == RISE + 3) begin
        check("rst mid hold valid before", 32'(VALID0), 32'd1);
        RST_N = 1'b0;
      end else if (s == RISE + 4) begin
        RST_N = 1'b1;
        model_hh[0] = 4'b0000;
        model_hh[1] = 4'b0000;
        exp_q.delete();
        check_idle_outputs("rst mid hold");
      end else if (s > RISE + 4) begin
        if (VALID0 || VALID1 || BUSY) saw++;
      end
    end
    check("held through reset activity", 32'(saw), 32'd0);
    SEND_N = 1'b1;
    repeat (DEB + 6) @(negedge CLK);
    check_idle_outputs("after release");

    // Randomized requests against the model.
    for (int k = 0; k < 20; k++) begin
      t = 1'($urandom);
      p = 3'($urandom_range(0, 7));
      f = 1'($urandom);
      o = 2'($urandom_range(0, 3));
      l = $urandom_range(1, 12);
      mask = (64'd1 << l) - 64'd1;
      run_txn("random", t, p, f, o, mask, 40, (l >= DEB) ? 1 : 0,
              4'(p * 2 + 3'(f)), 2'(3 - o));
    end

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
